// File: rtl/dcache_axi_master.sv
`default_nettype none
// ============================================================================
//  Module   : dcache_axi_master
//  Purpose  : AXI4 master bridge below the data cache. Runs one cache request
//             at a time as a single INCR burst: line fills on AR/R, write-backs
//             and uncached writes on AW/W/B. Read beats are registered back to
//             the cache; write beats pass straight through to W. A one-cycle
//             resp_valid pulse reports completion, resp_err flags SLVERR/DECERR,
//             an unexpected ID, or a burst-length mismatch.
//  Ports    : clk, rst_n              clock / async active-low reset
//             req_*                   cache request (valid/ready, we, addr, len, size)
//             wd_*                    cache write beats (valid/ready, data, strb)
//             rd_*                    read beats to cache (valid, data, last)
//             resp_valid, resp_err    completion pulse and error status
//             axi_ar*/r*/aw*/w*/b*    AXI4 master channels
//  Revision : 1.0  initial release
// ============================================================================
module dcache_axi_master #(
  parameter logic [3:0] AXI_ID = 4'd1,
  parameter int         ADDR_W = 32,
  parameter int         DATA_W = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // cache request
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [7:0]            req_len,
  input  logic [2:0]            req_size,
  // cache write beats
  input  logic                  wd_valid,
  output logic                  wd_ready,
  input  logic [DATA_W-1:0]     wd_data,
  input  logic [DATA_W/8-1:0]   wd_strb,
  // read beats to cache
  output logic                  rd_valid,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_last,
  // completion
  output logic                  resp_valid,
  output logic                  resp_err,
  // AXI read address
  output logic                  axi_arvalid,
  input  logic                  axi_arready,
  output logic [3:0]            axi_arid,
  output logic [ADDR_W-1:0]     axi_araddr,
  output logic [7:0]            axi_arlen,
  output logic [2:0]            axi_arsize,
  output logic [1:0]            axi_arburst,
  // AXI read data
  input  logic                  axi_rvalid,
  output logic                  axi_rready,
  input  logic [3:0]            axi_rid,
  input  logic [DATA_W-1:0]     axi_rdata,
  input  logic [1:0]            axi_rresp,
  input  logic                  axi_rlast,
  // AXI write address
  output logic                  axi_awvalid,
  input  logic                  axi_awready,
  output logic [3:0]            axi_awid,
  output logic [ADDR_W-1:0]     axi_awaddr,
  output logic [7:0]            axi_awlen,
  output logic [2:0]            axi_awsize,
  output logic [1:0]            axi_awburst,
  // AXI write data
  output logic                  axi_wvalid,
  input  logic                  axi_wready,
  output logic [DATA_W-1:0]     axi_wdata,
  output logic [DATA_W/8-1:0]   axi_wstrb,
  output logic                  axi_wlast,
  // AXI write response
  input  logic                  axi_bvalid,
  output logic                  axi_bready,
  input  logic [3:0]            axi_bid,
  input  logic [1:0]            axi_bresp
);

  localparam logic [1:0] BURST_INCR = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RADDR = 3'd1,
    ST_RDATA = 3'd2,
    ST_WADDR = 3'd3,
    ST_WRESP = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          len_q, len_d;
  logic [2:0]          size_q, size_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic                rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                rd_last_q, rd_last_d;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_err_q, resp_err_d;

  logic cnt_at_len;
  logic aw_hs;
  logic w_hs;
  logic r_beat_err;
  logic [7:0] cnt_inc;

  assign cnt_at_len = (cnt_q == len_q);
  // Saturate so a slave overrunning a 256-beat burst cannot wrap the counter.
  assign cnt_inc    = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  // Request / read-side outputs
  assign req_ready   = (state_q == ST_IDLE);
  assign axi_arvalid = (state_q == ST_RADDR);
  assign axi_arid    = AXI_ID;
  assign axi_araddr  = addr_q;
  assign axi_arlen   = len_q;
  assign axi_arsize  = size_q;
  assign axi_arburst = BURST_INCR;
  assign axi_rready  = (state_q == ST_RDATA);

  // Write-side outputs: AW and W run independently while in WADDR; each side
  // goes quiet once its own handshake (AW) or final beat (W) has completed.
  assign axi_awvalid = (state_q == ST_WADDR) && !aw_done_q;
  assign axi_awid    = AXI_ID;
  assign axi_awaddr  = addr_q;
  assign axi_awlen   = len_q;
  assign axi_awsize  = size_q;
  assign axi_awburst = BURST_INCR;
  assign axi_wvalid  = (state_q == ST_WADDR) && !w_done_q && wd_valid;
  assign axi_wdata   = wd_data;
  assign axi_wstrb   = wd_strb;
  assign axi_wlast   = cnt_at_len;
  assign wd_ready    = (state_q == ST_WADDR) && !w_done_q && axi_wready;
  assign axi_bready  = (state_q == ST_WRESP);

  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;
  assign rd_last     = rd_last_q;
  assign resp_valid  = resp_valid_q;
  assign resp_err    = resp_err_q;

  assign aw_hs = axi_awvalid && axi_awready;
  assign w_hs  = axi_wvalid && axi_wready;

  // A read beat is bad if the slave errored, used another ID, or its rlast
  // disagrees with our own beat count (early or missing last).
  assign r_beat_err = axi_rresp[1] | (axi_rid != AXI_ID) | (axi_rlast != cnt_at_len);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    len_d        = len_q;
    size_d       = size_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    rd_valid_d   = 1'b0;
    rd_data_d    = rd_data_q;
    rd_last_d    = 1'b0;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d    = req_addr;
          len_d     = req_len;
          size_d    = req_size;
          cnt_d     = 8'd0;
          err_d     = 1'b0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = req_we ? ST_WADDR : ST_RADDR;
        end
      end

      ST_RADDR: begin
        if (axi_arready) begin
          state_d = ST_RDATA;
        end
      end

      ST_RDATA: begin
        if (axi_rvalid) begin
          rd_valid_d = 1'b1;
          rd_data_d  = axi_rdata;
          rd_last_d  = cnt_at_len;
          cnt_d      = cnt_inc;
          err_d      = err_q | r_beat_err;
          // The slave's rlast always ends the burst, even when it disagrees
          // with the requested length; the mismatch is reported via resp_err.
          if (axi_rlast) begin
            resp_valid_d = 1'b1;
            resp_err_d   = err_q | r_beat_err;
            state_d      = ST_IDLE;
          end
        end
      end

      ST_WADDR: begin
        if (aw_hs) begin
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          cnt_d = cnt_inc;
          if (axi_wlast) begin
            w_done_d = 1'b1;
          end
        end
        if ((aw_done_q || aw_hs) && (w_done_q || (w_hs && axi_wlast))) begin
          state_d = ST_WRESP;
        end
      end

      ST_WRESP: begin
        if (axi_bvalid) begin
          resp_valid_d = 1'b1;
          resp_err_d   = axi_bresp[1] | err_q | (axi_bid != AXI_ID);
          state_d      = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      len_q        <= '0;
      size_q       <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      rd_last_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      size_q       <= size_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
      rd_last_q    <= rd_last_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dcache_axi_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dcache_axi_master
//  Purpose  : Self-checking bench for dcache_axi_master. A behavioural AXI
//             slave and cache driver issue directed and randomized bursts; the
//             expected beat stream, burst payload and completion status come
//             from a transaction-level model of each burst.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dcache_axi_master;

  localparam logic [3:0] AXI_ID = 4'd1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr;
  logic [7:0]  req_len;
  logic [2:0]  req_size;
  logic        wd_valid, wd_ready;
  logic [63:0] wd_data;
  logic [7:0]  wd_strb;
  logic        rd_valid, rd_last;
  logic [63:0] rd_data;
  logic        resp_valid, resp_err;
  logic        axi_arvalid, axi_arready;
  logic [3:0]  axi_arid;
  logic [31:0] axi_araddr;
  logic [7:0]  axi_arlen;
  logic [2:0]  axi_arsize;
  logic [1:0]  axi_arburst;
  logic        axi_rvalid, axi_rready, axi_rlast;
  logic [3:0]  axi_rid;
  logic [63:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_awvalid, axi_awready;
  logic [3:0]  axi_awid;
  logic [31:0] axi_awaddr;
  logic [7:0]  axi_awlen;
  logic [2:0]  axi_awsize;
  logic [1:0]  axi_awburst;
  logic        axi_wvalid, axi_wready, axi_wlast;
  logic [63:0] axi_wdata;
  logic [7:0]  axi_wstrb;
  logic        axi_bvalid, axi_bready;
  logic [3:0]  axi_bid;
  logic [1:0]  axi_bresp;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dcache_axi_master #(.AXI_ID(AXI_ID), .ADDR_W(32), .DATA_W(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_len(req_len), .req_size(req_size),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
    .resp_valid(resp_valid), .resp_err(resp_err),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_arid(axi_arid),
    .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
    .axi_arburst(axi_arburst),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rid(axi_rid),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awid(axi_awid),
    .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
    .axi_awburst(axi_awburst),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata),
    .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bid(axi_bid),
    .axi_bresp(axi_bresp)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    req_valid = 0; req_we = 0; req_addr = '0; req_len = '0; req_size = '0;
    wd_valid = 0; wd_data = '0; wd_strb = '0;
    axi_arready = 0; axi_rvalid = 0; axi_rid = AXI_ID; axi_rdata = '0;
    axi_rresp = 0; axi_rlast = 0; axi_awready = 0; axi_wready = 0;
    axi_bvalid = 0; axi_bid = AXI_ID; axi_bresp = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  // Present a request for one cycle; returns at the negedge after acceptance.
  task automatic issue_req(input logic we, input logic [31:0] addr,
                           input logic [7:0] len, input logic [2:0] size);
    req_valid = 1; req_we = we; req_addr = addr; req_len = len; req_size = size;
    #1;
    check_eq("req_ready_idle", req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    // scramble the request bus so the bridge must use its latched copy
    req_valid = 0; req_addr = $urandom; req_len = 8'($urandom); req_size = 3'($urandom);
  endtask

  // One read burst. nbeats is how many beats the slave actually returns,
  // so nbeats != len+1 models a misbehaving slave.
  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input int nbeats, input int stall, input bit bad_resp,
                         input bit bad_id, input bit fixed_data);
    bit          ar_done = 0;
    bit          pend = 0;
    bit          go;
    bit          exp_err;
    logic [63:0] pend_data = '0;
    logic        pend_last = 0;
    logic [63:0] data;
    int          beat = 0;
    int          cyc = 0;
    exp_err = bad_resp || bad_id || (nbeats != int'(len) + 1);
    issue_req(1'b0, addr, len, size);
    while (!ar_done && cyc < 200) begin
      axi_arready = ($urandom_range(99) >= stall);
      #1;
      check_eq("arvalid", axi_arvalid, 1);
      check_eq("araddr", axi_araddr, addr);
      check_eq("arlen", axi_arlen, len);
      check_eq("arsize", axi_arsize, size);
      check_eq("arburst", axi_arburst, 2'b01);
      check_eq("arid", axi_arid, AXI_ID);
      check_eq("rready_in_ar", axi_rready, 0);
      ar_done = axi_arvalid && axi_arready;
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    axi_arready = 0;
    check_eq("ar_handshake", ar_done, 1);
    cyc = 0;
    while (beat < nbeats && cyc < 4000) begin
      go = ($urandom_range(99) >= stall);
      data = fixed_data ? 64'h1111 * 64'(beat + 1) : {$urandom, $urandom};
      axi_rvalid = go;
      axi_rdata  = data;
      axi_rlast  = (beat == nbeats - 1);
      axi_rresp  = (bad_resp && beat == 0) ? 2'b10 : 2'b00;
      axi_rid    = (bad_id && beat == nbeats - 1) ? 4'd7 : AXI_ID;
      #1;
      check_eq("arvalid_in_r", axi_arvalid, 0);
      check_eq("rready", axi_rready, 1);
      check_eq("rd_valid", rd_valid, pend);
      if (pend) begin
        check_eq("rd_data", rd_data, pend_data);
        check_eq("rd_last", rd_last, pend_last);
      end
      check_eq("resp_valid_mid_r", resp_valid, 0);
      if (go && axi_rready) begin
        pend = 1; pend_data = data; pend_last = (beat == int'(len)); beat++;
      end else begin
        pend = 0;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    axi_rvalid = 0; axi_rlast = 0; axi_rid = AXI_ID; axi_rresp = 0;
    check_eq("r_beats", beat, nbeats);
    #1;
    check_eq("rd_valid_final", rd_valid, 1);
    check_eq("rd_data_final", rd_data, pend_data);
    check_eq("rd_last_final", rd_last, pend_last);
    check_eq("resp_valid_rd", resp_valid, 1);
    check_eq("resp_err_rd", resp_err, exp_err);
    check_eq("req_ready_after_rd", req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    #1;
    check_eq("resp_pulse_rd", resp_valid, 0);
    check_eq("rd_valid_after", rd_valid, 0);
    if (beat != nbeats) do_reset();
  endtask

  // One write burst. aw_delay holds awready low for that many cycles;
  // junk_after keeps wd_valid high after the last beat to probe the wvalid gate.
  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input int aw_delay, input int stall, input logic [1:0] bresp,
                          input bit bad_id, input bit junk_after, input logic [7:0] fix_strb);
    logic [63:0] wdat[$];
    logic [7:0]  wstb[$];
    bit          aw_done = 0;
    bit          aw_hs, w_hs;
    bit          exp_err;
    int          beat = 0;
    int          cyc = 0;
    int          bdly;
    exp_err = bresp[1] || bad_id;
    for (int i = 0; i <= int'(len); i++) begin
      wdat.push_back({$urandom, $urandom});
      wstb.push_back((fix_strb != 0) ? fix_strb : 8'($urandom));
    end
    issue_req(1'b1, addr, len, size);
    while (!(aw_done && beat > int'(len)) && cyc < 4000) begin
      axi_awready = (cyc >= aw_delay) && ($urandom_range(99) >= stall);
      axi_wready  = ($urandom_range(99) >= stall);
      if (beat <= int'(len)) begin
        wd_valid = ($urandom_range(99) >= stall);
        wd_data  = wdat[beat];
        wd_strb  = wstb[beat];
      end else begin
        wd_valid = junk_after;
        wd_data  = {$urandom, $urandom};
        wd_strb  = 8'($urandom);
      end
      #1;
      check_eq("awvalid", axi_awvalid, !aw_done);
      if (!aw_done) begin
        check_eq("awaddr", axi_awaddr, addr);
        check_eq("awlen", axi_awlen, len);
        check_eq("awsize", axi_awsize, size);
        check_eq("awburst", axi_awburst, 2'b01);
        check_eq("awid", axi_awid, AXI_ID);
      end
      check_eq("bready_in_w", axi_bready, 0);
      check_eq("resp_valid_mid_w", resp_valid, 0);
      if (beat <= int'(len)) begin
        check_eq("wvalid", axi_wvalid, wd_valid);
        check_eq("wd_ready", wd_ready, axi_wready);
        if (wd_valid) begin
          check_eq("wdata", axi_wdata, wdat[beat]);
          check_eq("wstrb", axi_wstrb, wstb[beat]);
          check_eq("wlast", axi_wlast, (beat == int'(len)));
        end
      end else begin
        check_eq("wvalid_after_last", axi_wvalid, 0);
      end
      aw_hs = axi_awvalid && axi_awready;
      w_hs  = axi_wvalid && axi_wready;
      @(posedge clk);
      if (aw_hs) aw_done = 1;
      if (w_hs) beat++;
      @(negedge clk);
      cyc++;
    end
    check_eq("w_phase_done", aw_done && beat > int'(len), 1);
    wd_valid = 0; axi_awready = 0; axi_wready = 0;
    bdly = $urandom_range(3);
    for (int i = 0; i < bdly; i++) begin
      #1;
      check_eq("bready_wait", axi_bready, 1);
      check_eq("resp_valid_wait", resp_valid, 0);
      @(posedge clk);
      @(negedge clk);
    end
    axi_bvalid = 1; axi_bresp = bresp; axi_bid = bad_id ? 4'd9 : AXI_ID;
    #1;
    check_eq("bready", axi_bready, 1);
    check_eq("wvalid_in_b", axi_wvalid, 0);
    @(posedge clk);
    @(negedge clk);
    axi_bvalid = 0; axi_bresp = 0; axi_bid = AXI_ID;
    #1;
    check_eq("resp_valid_wr", resp_valid, 1);
    check_eq("resp_err_wr", resp_err, exp_err);
    check_eq("req_ready_after_wr", req_ready, 1);
    check_eq("bready_after", axi_bready, 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    check_eq("resp_pulse_wr", resp_valid, 0);
    if (!(aw_done && beat > int'(len))) do_reset();
  endtask

  initial begin
    logic [7:0]  len;
    logic [2:0]  size;
    logic [31:0] addr;
    int          nb;
    idle_inputs();
    rst_n = 0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_req_ready", req_ready, 1);
    check_eq("rst_arvalid", axi_arvalid, 0);
    check_eq("rst_awvalid", axi_awvalid, 0);
    check_eq("rst_wvalid", axi_wvalid, 0);
    check_eq("rst_rready", axi_rready, 0);
    check_eq("rst_bready", axi_bready, 0);
    check_eq("rst_rd_valid", rd_valid, 0);
    check_eq("rst_resp_valid", resp_valid, 0);
    check_eq("rst_araddr", axi_araddr, 0);
    check_eq("rst_arlen", axi_arlen, 0);
    rst_n = 1;
    @(negedge clk);

    // Directed: 2-beat fill, no stalls, data 0x1111 / 0x2222
    do_read(32'h8000_0010, 8'd1, 3'd3, 2, 0, 0, 0, 1);
    // Directed: 2-beat write, awready held off 5 cycles, W finishes first
    do_write(32'h8000_0100, 8'd1, 3'd3, 5, 0, 2'b00, 0, 1, 8'h00);
    // Directed: single uncached write with SLVERR
    do_write(32'hA000_0000, 8'd0, 3'd2, 0, 0, 2'b10, 0, 0, 8'h0F);
    // Directed: slave ends a 2-beat read after one beat
    do_read(32'h8000_0020, 8'd1, 3'd3, 1, 0, 0, 0, 0);
    // Directed: slave omits rlast on the expected last beat
    do_read(32'h8000_0030, 8'd1, 3'd3, 3, 0, 0, 0, 0);
    // Directed: wrong RID / BID
    do_read(32'h8000_0040, 8'd3, 3'd3, 4, 0, 0, 1, 0);
    do_write(32'h8000_0050, 8'd2, 3'd3, 0, 0, 2'b00, 1, 0, 8'h00);

    // Reset in the middle of a read burst
    issue_req(1'b0, 32'h8000_0080, 8'd3, 3'd3);
    axi_arready = 1;
    @(posedge clk); @(negedge clk);
    axi_arready = 0;
    axi_rvalid = 1; axi_rdata = 64'hDEAD_BEEF_0000_0001; axi_rlast = 0;
    @(posedge clk); @(negedge clk);
    axi_rvalid = 0;
    #1;
    check_eq("pre_rst_rd_valid", rd_valid, 1);
    rst_n = 0;
    #1;
    check_eq("midrst_rd_valid", rd_valid, 0);
    check_eq("midrst_rready", axi_rready, 0);
    check_eq("midrst_arvalid", axi_arvalid, 0);
    check_eq("midrst_resp_valid", resp_valid, 0);
    check_eq("midrst_req_ready", req_ready, 1);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    #1;
    check_eq("postrst_req_ready", req_ready, 1);
    check_eq("postrst_rd_valid", rd_valid, 0);
    @(negedge clk);
    do_read(32'h8000_00C0, 8'd3, 3'd3, 4, 0, 0, 0, 0);

    // Randomized bursts with stalls and occasional misbehaviour
    for (int n = 0; n < 1000; n++) begin
      len  = ($urandom_range(9) == 0) ? 8'($urandom_range(255)) : 8'($urandom_range(15));
      size = 3'($urandom_range(3));
      addr = $urandom & 32'hFFFF_FFF0;
      if ($urandom_range(1) == 0) begin
        nb = int'(len) + 1;
        if ($urandom_range(19) == 0 && len > 0) nb = $urandom_range(int'(len), 1);
        else if ($urandom_range(19) == 0 && len < 8'd250) nb = int'(len) + 2;
        do_read(addr, len, size, nb, $urandom_range(60),
                ($urandom_range(15) == 0), ($urandom_range(15) == 0), 0);
      end else begin
        do_write(addr, len, size, $urandom_range(4), $urandom_range(60),
                 ($urandom_range(7) == 0) ? 2'b10 : 2'b00, ($urandom_range(15) == 0),
                 1'($urandom_range(1)), 8'h00);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
